// File: rtl/cordic_job_arbiter.sv
// cordic_job_arbiter: round-robin sharing of one CORDIC calculator among NUM_REQ requesters.
// Define CORDIC_ARB_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
module cordic_job_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [4*NUM_REQ-1:0]   req_op,
    input  logic [32*NUM_REQ-1:0]  req_x,
    input  logic [32*NUM_REQ-1:0]  req_y,
    input  logic [32*NUM_REQ-1:0]  req_z,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [31:0]            rsp_result,
    output logic                   rsp_err,
    output logic                   cordic_en,
    output logic [3:0]             cordic_op,
    output logic [31:0]            cordic_x,
    output logic [31:0]            cordic_y,
    output logic [31:0]            cordic_z,
    input  logic [31:0]            cordic_result,
    input  logic                   cordic_done,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cordic_job_arbiter: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_q, rr_d, id_q, id_d, gnt_id, hi_id, lo_id;
    logic [3:0]      op_q, op_d, op_sel;
    logic [31:0]     x_q, x_d, y_q, y_d, z_q, z_d, res_q, res_d, x_sel, y_sel, z_sel;
    logic            err_q, err_d, gnt_any, hi_any, lo_any;
`ifdef CORDIC_ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
`endif

    // Requesters at or above the pointer beat those below it; lowest index wins within each half.
    always_comb begin
        hi_id  = '0;
        lo_id  = '0;
        hi_any = 1'b0;
        lo_any = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && ID_W'(i) >= rr_q) begin
                hi_id  = ID_W'(i);
                hi_any = 1'b1;
            end else if (req_valid[i]) begin
                lo_id  = ID_W'(i);
                lo_any = 1'b1;
            end
        end
        gnt_any = hi_any | lo_any;
        gnt_id  = hi_any ? hi_id : lo_id;
    end

    always_comb begin
        op_sel    = '0;
        x_sel     = '0;
        y_sel     = '0;
        z_sel     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id == ID_W'(i)) begin
                op_sel = req_op[4*i +: 4];
                x_sel  = req_x[32*i +: 32];
                y_sel  = req_y[32*i +: 32];
                z_sel  = req_z[32*i +: 32];
            end
            req_ready[i] = state_q == IDLE && !rst && gnt_any && gnt_id == ID_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        res_d   = res_q;
        err_d   = err_q;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d   = state_q == BUSY ? cnt_q + 16'd1 : 16'd0;
`endif
        if (state_q == IDLE && gnt_any) begin
            id_d    = gnt_id;
            op_d    = op_sel;
            x_d     = x_sel;
            y_d     = y_sel;
            z_d     = z_sel;
            res_d   = '0;
            err_d   = op_sel > 4'd9;
            state_d = op_sel > 4'd9 ? RESP : BUSY;
        end else if (state_q == BUSY && cordic_done) begin
            res_d   = cordic_result;
            err_d   = 1'b0;
            state_d = RESP;
`ifdef CORDIC_ARB_TIMEOUT_EN
        end else if (state_q == BUSY && cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
`endif
        end else if (state_q == RESP && rsp_ready) begin
            rr_d    = ID_W'((int'(id_q) + 1) % NUM_REQ);
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

`ifdef CORDIC_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        cnt_q <= rst ? 16'd0 : cnt_d;
    end
`endif

    assign busy       = state_q != IDLE;
    assign cordic_en  = state_q == BUSY;
    assign cordic_op  = cordic_en ? op_q : '0;
    assign cordic_x   = cordic_en ? x_q : '0;
    assign cordic_y   = cordic_en ? y_q : '0;
    assign cordic_z   = cordic_en ? z_q : '0;
    assign rsp_valid  = state_q == RESP;
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_err    = err_q;
endmodule

// File: tb/tb_cordic_job_arbiter.sv
// tb_cordic_job_arbiter: directed vector bench for cordic_job_arbiter with a fixed-latency calculator model.
module tb_cordic_job_arbiter;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_ready;
    logic [15:0]  req_op = '0;
    logic [127:0] req_x = '0;
    logic [127:0] req_y = '0;
    logic [127:0] req_z = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result;
    logic         rsp_err;
    logic         cordic_en;
    logic [3:0]   cordic_op;
    logic [31:0]  cordic_x, cordic_y, cordic_z, cordic_result;
    logic         cordic_done;
    logic         busy;
    logic         never_done = 1'b0;
    logic [7:0]   mcnt = '0;
    logic signed [63:0] prod;
    int           n_chk = 0;
    int           n_fail = 0;

    cordic_job_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .cordic_en(cordic_en), .cordic_op(cordic_op),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_z(cordic_z),
        .cordic_result(cordic_result), .cordic_done(cordic_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Calculator: done in the 18th enabled cycle; op 4 is a Q16.16 multiply, others sum the operands.
    always @(posedge clk) mcnt <= cordic_en ? mcnt + 8'd1 : 8'd0;
    assign cordic_done   = cordic_en && !never_done && mcnt == 8'd17;
    assign prod          = $signed(cordic_x) * $signed(cordic_z);
    assign cordic_result = cordic_op == 4'd4 ? prod[47:16] : cordic_x + cordic_y + cordic_z;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] ops;
        logic [1:0]  id;
        logic        err;
        logic [31:0] res;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a falling edge with the arbiter idle; returns at a falling edge, idle again.
    task automatic run_job(input logic [3:0] v, input logic [15:0] ops, input logic [1:0] eid,
                           input logic eerr, input logic [31:0] eres, input int een);
        int en_n;
        logic [3:0] eop;
        en_n = 0;
        eop = ops[4*eid +: 4];
        req_valid = v;
        req_op = ops;
        #1;
        chk("grant", 32'(req_ready), 32'(4'b0001 << eid));
        @(negedge clk);
        for (int c = 0; c < 200 && !rsp_valid; c++) begin
            if (en_n == 0) begin
                chk("cordic_op", 32'(cordic_op), 32'(eop));
                chk("cordic_x", cordic_x, (32'(eid) + 32'd2) << 16);
                chk("cordic_z", cordic_z, (32'(eid) + 32'd3) << 16);
                chk("ready_busy", 32'(req_ready), 32'd0);
            end
            en_n += int'(cordic_en);
            @(negedge clk);
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(eid));
        chk("rsp_err", 32'(rsp_err), 32'(eerr));
        chk("rsp_result", rsp_result, eres);
        chk("en_cycles", 32'(en_n), 32'(een));
        chk("en_in_resp", 32'(cordic_en), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = '0;
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        for (int i = 0; i < 4; i++) begin
            req_x[32*i +: 32] = (32'(i) + 32'd2) << 16;
            req_y[32*i +: 32] = 32'(i) << 16;
            req_z[32*i +: 32] = (32'(i) + 32'd3) << 16;
        end
        tbl[0]  = '{4'hF, 16'h4444, 2'd0, 1'b0, 32'h0006_0000};
        tbl[1]  = '{4'hF, 16'h4444, 2'd1, 1'b0, 32'h000C_0000};
        tbl[2]  = '{4'hF, 16'h4444, 2'd2, 1'b0, 32'h0014_0000};
        tbl[3]  = '{4'hF, 16'h4444, 2'd3, 1'b0, 32'h001E_0000};
        tbl[4]  = '{4'hF, 16'h4444, 2'd0, 1'b0, 32'h0006_0000};
        tbl[5]  = '{4'hF, 16'h4444, 2'd1, 1'b0, 32'h000C_0000};
        tbl[6]  = '{4'hF, 16'h4444, 2'd2, 1'b0, 32'h0014_0000};
        tbl[7]  = '{4'hF, 16'h4444, 2'd3, 1'b0, 32'h001E_0000};
        tbl[8]  = '{4'h1, 16'h4444, 2'd0, 1'b0, 32'h0006_0000};
        tbl[9]  = '{4'h5, 16'h4444, 2'd2, 1'b0, 32'h0014_0000};
        tbl[10] = '{4'h3, 16'h4444, 2'd0, 1'b0, 32'h0006_0000};
        tbl[11] = '{4'h8, 16'h4444, 2'd3, 1'b0, 32'h001E_0000};
        tbl[12] = '{4'h4, 16'h0C00, 2'd2, 1'b1, 32'h0000_0000};
        tbl[13] = '{4'h6, 16'h0090, 2'd1, 1'b0, 32'h0008_0000};
        tbl[14] = '{4'h1, 16'h000A, 2'd0, 1'b1, 32'h0000_0000};
        tbl[15] = '{4'hB, 16'h4444, 2'd1, 1'b0, 32'h000C_0000};

        req_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(cordic_en), 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_id, 28'd0}, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        chk("rst_cordic_x", cordic_x, 32'd0);
        req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 16; i++)
            run_job(tbl[i].v, tbl[i].ops, tbl[i].id, tbl[i].err, tbl[i].res, tbl[i].err ? 0 : 18);

        req_valid = 4'b0001;
        req_op = 16'h4444;
        #1;
        chk("bp_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 4'b0010;
        for (int c = 0; c < 50 && !rsp_valid; c++) @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_hold_ctl", {rsp_valid, rsp_err, rsp_id, req_ready}, {1'b1, 1'b0, 2'd0, 4'd0});
            chk("bp_hold_result", rsp_result, 32'h0006_0000);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_no_early_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_released", 32'(rsp_valid), 32'd0);
        chk("bp_next_grant", 32'(req_ready), 32'b0010);
        req_valid = '0;

        req_valid = 4'b1000;
        #1;
        chk("mid_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        chk("mid_busy_en", 32'(cordic_en), 32'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", 32'(cordic_en), 32'd0);
        chk("mid_rst_state", {busy, rsp_valid, req_ready}, 32'd0);
        chk("mid_rst_cordic_x", cordic_x, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            seen |= rsp_valid | busy;
            @(negedge clk);
        end
        chk("mid_no_rsp", 32'(seen), 32'd0);
        run_job(4'hF, 16'h4444, 2'd0, 1'b0, 32'h0006_0000, 18);

`ifdef CORDIC_ARB_TIMEOUT_EN
        never_done = 1'b1;
        run_job(4'b0001, 16'h4444, 2'd0, 1'b1, 32'h0, 64);
        never_done = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
